// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution with prediction pipeline and perf counters
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_PrPCSrc_F,
  input  logic [31:0]      i_PrALUResult_F,
  input  logic             i_StallD,
  input  logic             i_FlushD_ext,
  input  logic             i_FlushE_ext,
  input  logic [31:0]      i_PC_E,
  input  logic             i_Branch_E,
  input  logic             i_PCSrc_E,
  input  logic [31:0]      i_ALUResult_E,
  input  logic             i_CntClr,
  output logic             o_Redirect_E,
  output logic [31:0]      o_RedirectPC_E,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_WE_PrPCSrc,
  output logic             o_WE_PrALUResult,
  output logic [CNT_W-1:0] o_BranchCount,
  output logic [CNT_W-1:0] o_MispredCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_pr_pcsrc_d;
  logic [31:0]      r_pr_ta_d;
  logic             r_pr_pcsrc_e;
  logic [31:0]      r_pr_ta_e;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_dir_mis;
  logic             w_ta_mis;
  logic             w_redirect;
  logic             w_flush_d;
  logic             w_flush_e;
  logic [31:0]      w_pc_plus4;

  // Direction is checked for every instruction so aliased non-branches get trained toward not-taken.
  assign w_dir_mis  = (i_PCSrc_E != r_pr_pcsrc_e);
  assign w_ta_mis   = i_Branch_E & i_PCSrc_E & r_pr_pcsrc_e & (i_ALUResult_E != r_pr_ta_e);
  assign w_redirect = w_dir_mis | w_ta_mis;
  assign w_pc_plus4 = i_PC_E + 32'd4;
  assign w_flush_d  = i_FlushD_ext | w_redirect;
  assign w_flush_e  = i_FlushE_ext | w_redirect;

  assign o_Redirect_E     = w_redirect;
  assign o_RedirectPC_E   = i_PCSrc_E ? i_ALUResult_E : w_pc_plus4;
  assign o_FlushD         = w_flush_d;
  assign o_FlushE         = w_flush_e;
  assign o_WE_PrPCSrc     = w_dir_mis;
  assign o_WE_PrALUResult = (i_Branch_E & i_PCSrc_E & ~r_pr_pcsrc_e) | w_ta_mis;
  assign o_BranchCount    = r_branch_cnt;
  assign o_MispredCount   = r_mispred_cnt;

  // Flush takes priority over stall so a redirect never leaves a stale prediction in Decode.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pr_pcsrc_d <= 1'b0;
      r_pr_ta_d    <= 32'd0;
      r_pr_pcsrc_e <= 1'b0;
      r_pr_ta_e    <= 32'd0;
    end else begin
      if (w_flush_d) begin
        r_pr_pcsrc_d <= 1'b0;
        r_pr_ta_d    <= 32'd0;
      end else if (!i_StallD) begin
        r_pr_pcsrc_d <= i_PrPCSrc_F;
        r_pr_ta_d    <= i_PrALUResult_F;
      end
      if (w_flush_e) begin
        r_pr_pcsrc_e <= 1'b0;
        r_pr_ta_e    <= 32'd0;
      end else begin
        r_pr_pcsrc_e <= r_pr_pcsrc_d;
        r_pr_ta_e    <= r_pr_ta_d;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (i_CntClr) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (i_Branch_E && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      end
      if (w_redirect && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        PrPCSrc_F;
  logic [31:0] PrALUResult_F;
  logic        StallD, FlushD_ext, FlushE_ext;
  logic [31:0] PC_E;
  logic        Branch_E, PCSrc_E;
  logic [31:0] ALUResult_E;
  logic        CntClr;

  logic        red32, fd32, fe32, wd32, wt32;
  logic [31:0] rpc32, bc32, mc32;
  logic        red4, fd4, fe4, wd4, wt4;
  logic [31:0] rpc4;
  logic [3:0]  bc4, mc4;

  always #5 clk = ~clk;

  branch_resolve_unit u_dut32 (
    .clk(clk), .nrst(nrst), .i_PrPCSrc_F(PrPCSrc_F), .i_PrALUResult_F(PrALUResult_F),
    .i_StallD(StallD), .i_FlushD_ext(FlushD_ext), .i_FlushE_ext(FlushE_ext), .i_PC_E(PC_E),
    .i_Branch_E(Branch_E), .i_PCSrc_E(PCSrc_E), .i_ALUResult_E(ALUResult_E), .i_CntClr(CntClr),
    .o_Redirect_E(red32), .o_RedirectPC_E(rpc32), .o_FlushD(fd32), .o_FlushE(fe32),
    .o_WE_PrPCSrc(wd32), .o_WE_PrALUResult(wt32), .o_BranchCount(bc32), .o_MispredCount(mc32)
  );

  branch_resolve_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .i_PrPCSrc_F(PrPCSrc_F), .i_PrALUResult_F(PrALUResult_F),
    .i_StallD(StallD), .i_FlushD_ext(FlushD_ext), .i_FlushE_ext(FlushE_ext), .i_PC_E(PC_E),
    .i_Branch_E(Branch_E), .i_PCSrc_E(PCSrc_E), .i_ALUResult_E(ALUResult_E), .i_CntClr(CntClr),
    .o_Redirect_E(red4), .o_RedirectPC_E(rpc4), .o_FlushD(fd4), .o_FlushE(fe4),
    .o_WE_PrPCSrc(wd4), .o_WE_PrALUResult(wt4), .o_BranchCount(bc4), .o_MispredCount(mc4)
  );

  typedef struct {
    logic        red;
    logic [31:0] rpc;
    logic        wd;
    logic        wt;
  } exp_t;

  typedef struct {
    logic        pr;
    logic [31:0] ta;
    logic [31:0] pc;
    logic        br;
    logic        src;
    logic [31:0] alu;
    logic        e_red;
    logic [31:0] e_rpc;
    logic        e_wd;
    logic        e_wt;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];
  vec_t vecs[8];

  logic [31:0] exp_bc32, exp_mc32;
  logic [3:0]  exp_bc4, exp_mc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic red, input logic [31:0] rpc, input logic wd, input logic wt);
    exp_t e;
    e.red = red; e.rpc = rpc; e.wd = wd; e.wt = wt;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    @(negedge clk);
    n_tests++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      n_tests--;
      e = sbq.pop_front();
      chk({name, ".redirect"}, red32, e.red);
      chk({name, ".redirect_pc"}, rpc32, e.rpc);
      chk({name, ".we_dir"}, wd32, e.wd);
      chk({name, ".we_ta"}, wt32, e.wt);
      chk({name, ".flushd"}, fd32, FlushD_ext | e.red);
      chk({name, ".flushe"}, fe32, FlushE_ext | e.red);
      chk({name, ".redirect_w4"}, red4, e.red);
    end
  endtask

  task automatic chk_cnt(input string name);
    chk({name, ".bc32"}, bc32, exp_bc32);
    chk({name, ".mc32"}, mc32, exp_mc32);
    chk({name, ".bc4"}, {28'd0, bc4}, {28'd0, exp_bc4});
    chk({name, ".mc4"}, {28'd0, mc4}, {28'd0, exp_mc4});
  endtask

  // One clock edge; the counter model advances with what the bench expects at that edge.
  task automatic step(input logic br, input logic red);
    @(posedge clk);
    if (CntClr) begin
      exp_bc32 = '0; exp_mc32 = '0; exp_bc4 = '0; exp_mc4 = '0;
    end else begin
      if (br  && exp_bc32 != '1) exp_bc32 = exp_bc32 + 32'd1;
      if (red && exp_mc32 != '1) exp_mc32 = exp_mc32 + 32'd1;
      if (br  && exp_bc4  != '1) exp_bc4  = exp_bc4 + 4'd1;
      if (red && exp_mc4  != '1) exp_mc4  = exp_mc4 + 4'd1;
    end
    #1;
  endtask

  task automatic drive_e(input logic [31:0] pc, input logic br, input logic src, input logic [31:0] alu);
    PC_E = pc; Branch_E = br; PCSrc_E = src; ALUResult_E = alu;
  endtask

  task automatic flush_pipe();
    PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0; StallD = 1'b0;
    FlushD_ext = 1'b1; FlushE_ext = 1'b1;
    drive_e(32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0);
    FlushD_ext = 1'b0; FlushE_ext = 1'b0;
  endtask

  task automatic load_e(input logic pr, input logic [31:0] ta);
    flush_pipe();
    PrPCSrc_F = pr; PrALUResult_F = ta;
    step(1'b0, 1'b0);
    PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    //           pr    ta            pc            br    src   alu           red   rpc           wd    wt
    vecs[0] = '{1'b1, 32'h00000100, 32'h00000050, 1'b1, 1'b1, 32'h00000100, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h00000000, 32'h00000040, 1'b1, 1'b1, 32'h00000080, 1'b1, 32'h00000080, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h00000200, 32'h00000060, 1'b1, 1'b1, 32'h00000240, 1'b1, 32'h00000240, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h00000300, 32'h0000001C, 1'b0, 1'b0, 32'h00000999, 1'b1, 32'h00000020, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h00000500, 32'h00000070, 1'b1, 1'b0, 32'h00000500, 1'b1, 32'h00000074, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h00000000, 32'h00000080, 1'b1, 1'b0, 32'h00001234, 1'b0, 32'h00000084, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h00000000, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h80000100, 32'h00000090, 1'b1, 1'b1, 32'h00000100, 1'b1, 32'h00000100, 1'b0, 1'b1};

    exp_bc32 = '0; exp_mc32 = '0; exp_bc4 = '0; exp_mc4 = '0;
    nrst = 1'b0; CntClr = 1'b0;
    PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0; StallD = 1'b0; FlushD_ext = 1'b0; FlushE_ext = 1'b0;
    drive_e(32'd0, 1'b0, 1'b0, 32'd0);

    expect_out(1'b0, 32'h4, 1'b0, 1'b0);
    check_out("reset");
    chk_cnt("reset");
    @(posedge clk); #1;
    nrst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load_e(vecs[i].pr, vecs[i].ta);
      drive_e(vecs[i].pc, vecs[i].br, vecs[i].src, vecs[i].alu);
      expect_out(vecs[i].e_red, vecs[i].e_rpc, vecs[i].e_wd, vecs[i].e_wt);
      check_out($sformatf("vec%0d", i));
      step(vecs[i].br, vecs[i].e_red);
      chk_cnt($sformatf("vec%0d", i));
    end

    // Redirect flushes its own E register, and beats StallD on the D register.
    flush_pipe();
    step(1'b0, 1'b0);
    PrPCSrc_F = 1'b1; PrALUResult_F = 32'h700;
    step(1'b0, 1'b0);
    StallD = 1'b1; PrALUResult_F = 32'h900;
    drive_e(32'h40, 1'b1, 1'b1, 32'h80);
    expect_out(1'b1, 32'h80, 1'b1, 1'b1);
    check_out("redir_stall");
    step(1'b1, 1'b1);
    StallD = 1'b0; PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
    drive_e(32'd0, 1'b0, 1'b0, 32'd0);
    expect_out(1'b0, 32'h4, 1'b0, 1'b0);
    check_out("bubble_after_redir");
    step(1'b0, 1'b0);
    expect_out(1'b0, 32'h4, 1'b0, 1'b0);
    check_out("d_cleared_despite_stall");
    step(1'b0, 1'b0);
    chk_cnt("seq_redir");

    // Stalled prediction survives three cycles; a FlushE_ext pulse turns it into a bubble.
    flush_pipe();
    PrPCSrc_F = 1'b1; PrALUResult_F = 32'h400;
    step(1'b0, 1'b0);
    StallD = 1'b1; FlushE_ext = 1'b1; PrALUResult_F = 32'hBAD0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    expect_out(1'b0, 32'h4, 1'b0, 1'b0);
    check_out("during_stall");
    StallD = 1'b0; FlushE_ext = 1'b0; PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
    step(1'b0, 1'b0);
    drive_e(32'h90, 1'b1, 1'b1, 32'h400);
    expect_out(1'b0, 32'h400, 1'b0, 1'b0);
    check_out("stall_intact");
    step(1'b1, 1'b0);
    drive_e(32'd0, 1'b0, 1'b0, 32'd0);
    PrPCSrc_F = 1'b1; PrALUResult_F = 32'h400;
    step(1'b0, 1'b0);
    FlushE_ext = 1'b1; PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
    step(1'b0, 1'b0);
    FlushE_ext = 1'b0;
    drive_e(32'hA0, 1'b0, 1'b0, 32'd0);
    expect_out(1'b0, 32'hA4, 1'b0, 1'b0);
    check_out("flushe_bubble");
    step(1'b0, 1'b0);
    chk_cnt("seq_stall");

    // Reset in the middle of a redirect drops the prediction and counters at once.
    flush_pipe();
    PrPCSrc_F = 1'b1; PrALUResult_F = 32'h500;
    step(1'b0, 1'b0);
    PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
    step(1'b0, 1'b0);
    drive_e(32'h40, 1'b1, 1'b0, 32'd0);
    #1;
    nrst = 1'b0;
    exp_bc32 = '0; exp_mc32 = '0; exp_bc4 = '0; exp_mc4 = '0;
    #1;
    chk_cnt("async_reset");
    expect_out(1'b0, 32'h44, 1'b0, 1'b0);
    check_out("reset_no_taken");
    drive_e(32'h40, 1'b1, 1'b1, 32'h500);
    expect_out(1'b1, 32'h500, 1'b1, 1'b1);
    check_out("reset_taken");
    @(posedge clk); #1;
    nrst = 1'b1;
    drive_e(32'h60, 1'b0, 1'b0, 32'd0);
    expect_out(1'b0, 32'h64, 1'b0, 1'b0);
    check_out("after_reset");
    step(1'b0, 1'b0);
    chk_cnt("after_reset");

    // Counter saturation on the narrow instance, then clear beats a same-cycle increment.
    drive_e(32'h40, 1'b1, 1'b1, 32'h80);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    chk("sat.mc4_is_f", {28'd0, mc4}, 32'hF);
    chk_cnt("saturate");
    CntClr = 1'b1;
    step(1'b1, 1'b1);
    CntClr = 1'b0;
    drive_e(32'd0, 1'b0, 1'b0, 32'd0);
    chk_cnt("cntclr");

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
